// File: rtl/ahb_decoder_ctrl.sv
// ahb_decoder_ctrl
// AHB-Lite address decoder with a registered one-hot data-phase select for the
// slave response mux, plus the built-in default slave. The default slave gives
// a two-cycle ERROR response to active transfers that fall into unmapped
// regions and keeps a saturating count of the errors it has issued.
module ahb_decoder_ctrl #(
    parameter int NO_OF_SLAVES = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int REGION_BITS  = 4
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HREADY,
    input  logic                    ERR_CLR,
    output logic [NO_OF_SLAVES-1:0] HSEL,
    output logic [NO_OF_SLAVES:0]   HSEL_DP,
    output logic                    DEF_HREADYOUT,
    output logic                    DEF_HRESP,
    output logic [DATA_WIDTH-1:0]   DEF_HRDATA,
    output logic [7:0]              ERR_COUNT
);

    // Default-slave response states. ERR1 is the wait cycle of the ERROR
    // response, ERR2 the completing cycle.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    logic [REGION_BITS-1:0]  w_region;
    logic [NO_OF_SLAVES-1:0] w_hsel;
    logic                    w_def_sel;
    logic                    w_err_start;
    logic [1:0]              w_state_next;
    logic                    w_err_entry;
    logic                    w_unused_inputs;

    logic [1:0]              r_state;
    logic [NO_OF_SLAVES:0]   r_hsel_dp;
    logic                    r_hreadyout;
    logic                    r_hresp;
    logic [7:0]              r_err_count;

    // Only the top REGION_BITS of the address and HTRANS[1] take part in decode.
    assign w_unused_inputs = ^{HADDR[ADDR_WIDTH-REGION_BITS-1:0], HTRANS[0]};

    assign w_region    = HADDR[ADDR_WIDTH-1 -: REGION_BITS];
    assign w_def_sel   = (w_region >= REGION_BITS'(NO_OF_SLAVES));
    // An active (NONSEQ/SEQ) transfer accepted into an unmapped region.
    assign w_err_start = HREADY & w_def_sel & HTRANS[1];

    // Address-phase decode: one select line per mapped region, independent of HTRANS.
    always_comb begin
        // NOTE: every combinational output gets a value on every path (here the
        // loop covers all bits) so no latch is inferred.
        w_hsel = '0;
        for (int i = 0; i < NO_OF_SLAVES; i++) begin
            w_hsel[i] = (w_region == REGION_BITS'(i));
        end
    end

    // Data-phase select: capture the address-phase decode only when the bus
    // advances, so wait states keep the current slave on the response mux.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            r_hsel_dp <= '0;
        end else if (HREADY) begin
            r_hsel_dp <= {w_def_sel, w_hsel};
        end
    end

    // Default-slave next-state logic.
    always_comb begin
        w_state_next = ST_IDLE;
        case (r_state)
            ST_IDLE: w_state_next = w_err_start ? ST_ERR1 : ST_IDLE;
            ST_ERR1: w_state_next = ST_ERR2;
            ST_ERR2: w_state_next = w_err_start ? ST_ERR1 : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ERR1 is only ever entered from another state, so reaching it marks a new error.
    assign w_err_entry = (w_state_next == ST_ERR1);

    // Default-slave state and its registered (Moore) response outputs.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_hreadyout <= (w_state_next != ST_ERR1);
            r_hresp     <= (w_state_next != ST_IDLE);
        end
    end

    // Saturating error counter; a clear wins over a simultaneous increment.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_err_count <= 8'd0;
        end else if (ERR_CLR) begin
            r_err_count <= 8'd0;
        end else if (w_err_entry && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign HSEL          = w_hsel;
    assign HSEL_DP       = r_hsel_dp;
    assign DEF_HREADYOUT = r_hreadyout;
    assign DEF_HRESP     = r_hresp;
    assign DEF_HRDATA    = {DATA_WIDTH{1'b0}};
    assign ERR_COUNT     = r_err_count;

endmodule

// File: tb/tb_ahb_decoder_ctrl.sv
// Self-checking bench for ahb_decoder_ctrl (NO_OF_SLAVES=2, REGION_BITS=4).
// Directed table, hand-written reset/saturation sequences and randomized
// traffic checked against a transaction-level model of the decoder.
module tb_ahb_decoder_ctrl;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        HCLK;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic        ERR_CLR;
    logic [1:0]  HSEL;
    logic [2:0]  HSEL_DP;
    logic        DEF_HREADYOUT;
    logic        DEF_HRESP;
    logic [31:0] DEF_HRDATA;
    logic [7:0]  ERR_COUNT;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: data-phase select, which cycle of an error response the
    // default slave is in (0 none, 1 first/wait, 2 second/final), error count.
    logic [2:0] m_dp;
    int         m_phase;
    int         m_cnt;

    ahb_decoder_ctrl #(
        .NO_OF_SLAVES(2),
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .REGION_BITS (4)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HADDR        (HADDR),
        .HTRANS       (HTRANS),
        .HREADY       (HREADY),
        .ERR_CLR      (ERR_CLR),
        .HSEL         (HSEL),
        .HSEL_DP      (HSEL_DP),
        .DEF_HREADYOUT(DEF_HREADYOUT),
        .DEF_HRESP    (DEF_HRESP),
        .DEF_HRDATA   (DEF_HRDATA),
        .ERR_COUNT    (ERR_COUNT)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        ready;
        logic        clr;
        logic [1:0]  hsel;
        logic [2:0]  dp;
        logic        rdy;
        logic        resp;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] model_hsel(input logic [31:0] a);
        int r;
        r = int'(a[31:28]);
        return (r < 2) ? 2'(1 << r) : 2'b00;
    endfunction

    task automatic model_reset();
        m_dp    = 3'b000;
        m_phase = 0;
        m_cnt   = 0;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic rdy, input logic clr);
        HADDR   = a;
        HTRANS  = t;
        HREADY  = rdy;
        ERR_CLR = clr;
        #1;
    endtask

    // Advance one clock edge and update the model from the inputs presented.
    task automatic clock_edge();
        int r;
        bit unmapped;
        bit start;
        r        = int'(HADDR[31:28]);
        unmapped = (r >= 2);
        start    = HREADY && unmapped && HTRANS[1];
        @(posedge HCLK);
        if (HREADY) m_dp = unmapped ? 3'b100 : 3'(1 << r);
        if (m_phase == 1)  m_phase = 2;
        else if (start)    m_phase = 1;
        else               m_phase = 0;
        if (ERR_CLR)                        m_cnt = 0;
        else if (m_phase == 1 && m_cnt < 255) m_cnt = m_cnt + 1;
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".hsel_dp"},   32'(HSEL_DP),       32'(m_dp));
        check({tag, ".hreadyout"}, 32'(DEF_HREADYOUT), 32'(m_phase != 1));
        check({tag, ".hresp"},     32'(DEF_HRESP),     32'(m_phase != 0));
        check({tag, ".err_count"}, 32'(ERR_COUNT),     32'(m_cnt));
    endtask

    // One modelled transfer: check zero-latency decode, clock, check registered outputs.
    task automatic step(input string tag, input logic [31:0] a, input logic [1:0] t,
                        input logic rdy, input logic clr);
        drive(a, t, rdy, clr);
        check({tag, ".hsel"}, 32'(HSEL), 32'(model_hsel(a)));
        clock_edge();
        check_model(tag);
    endtask

    initial begin
        // Directed vectors, starting just after reset with ERR_COUNT = 0.
        vecs[0]  = '{32'h0000_0010, T_NONSEQ, 1'b1, 1'b0, 2'b01, 3'b001, 1'b1, 1'b0, 8'd0};
        vecs[1]  = '{32'h1000_0000, T_NONSEQ, 1'b1, 1'b0, 2'b10, 3'b010, 1'b1, 1'b0, 8'd0};
        vecs[2]  = '{32'h2000_0000, T_NONSEQ, 1'b1, 1'b0, 2'b00, 3'b100, 1'b0, 1'b1, 8'd1};
        vecs[3]  = '{32'h0000_0000, T_IDLE,   1'b0, 1'b0, 2'b01, 3'b100, 1'b1, 1'b1, 8'd1};
        vecs[4]  = '{32'h0000_0000, T_IDLE,   1'b1, 1'b0, 2'b01, 3'b001, 1'b1, 1'b0, 8'd1};
        vecs[5]  = '{32'hF000_0000, T_IDLE,   1'b1, 1'b0, 2'b00, 3'b100, 1'b1, 1'b0, 8'd1};
        vecs[6]  = '{32'h2000_0000, T_NONSEQ, 1'b1, 1'b0, 2'b00, 3'b100, 1'b0, 1'b1, 8'd2};
        vecs[7]  = '{32'h2000_0000, T_NONSEQ, 1'b0, 1'b0, 2'b00, 3'b100, 1'b1, 1'b1, 8'd2};
        vecs[8]  = '{32'h2000_0000, T_NONSEQ, 1'b1, 1'b0, 2'b00, 3'b100, 1'b0, 1'b1, 8'd3};
        vecs[9]  = '{32'h2000_0000, T_SEQ,    1'b0, 1'b0, 2'b00, 3'b100, 1'b1, 1'b1, 8'd3};
        vecs[10] = '{32'h0000_0000, T_IDLE,   1'b1, 1'b0, 2'b01, 3'b001, 1'b1, 1'b0, 8'd3};
        vecs[11] = '{32'h0000_0040, T_NONSEQ, 1'b1, 1'b0, 2'b01, 3'b001, 1'b1, 1'b0, 8'd3};
        vecs[12] = '{32'h1000_0000, T_NONSEQ, 1'b0, 1'b0, 2'b10, 3'b001, 1'b1, 1'b0, 8'd3};
        vecs[13] = '{32'h1000_0000, T_NONSEQ, 1'b0, 1'b0, 2'b10, 3'b001, 1'b1, 1'b0, 8'd3};
        vecs[14] = '{32'h1000_0000, T_NONSEQ, 1'b0, 1'b0, 2'b10, 3'b001, 1'b1, 1'b0, 8'd3};
        vecs[15] = '{32'h1000_0000, T_NONSEQ, 1'b1, 1'b0, 2'b10, 3'b010, 1'b1, 1'b0, 8'd3};
        vecs[16] = '{32'h3000_0000, T_BUSY,   1'b1, 1'b0, 2'b00, 3'b100, 1'b1, 1'b0, 8'd3};
        vecs[17] = '{32'h0000_0000, T_IDLE,   1'b1, 1'b1, 2'b01, 3'b001, 1'b1, 1'b0, 8'd0};

        // Reset: outputs must take reset values before any clock edge.
        HRESET = 1'b1;
        drive(32'h0, T_IDLE, 1'b1, 1'b0);
        model_reset();
        #1;
        check("rst_async.hsel_dp",   32'(HSEL_DP),       32'h0);
        check("rst_async.hreadyout", 32'(DEF_HREADYOUT), 32'h1);
        check("rst_async.hresp",     32'(DEF_HRESP),     32'h0);
        check("rst_async.err_count", 32'(ERR_COUNT),     32'h0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        #1 HRESET = 1'b0;
        #1;
        check("rst_rel.hsel_dp",   32'(HSEL_DP),       32'h0);
        check("rst_rel.hreadyout", 32'(DEF_HREADYOUT), 32'h1);
        check("rst_rel.hresp",     32'(DEF_HRESP),     32'h0);
        check("rst_rel.err_count", 32'(ERR_COUNT),     32'h0);
        check("rst_rel.hrdata",    DEF_HRDATA,         32'h0);

        // Directed table.
        for (int i = 0; i < 18; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].addr, vecs[i].trans, vecs[i].ready, vecs[i].clr);
            check({tag, ".hsel"}, 32'(HSEL), 32'(vecs[i].hsel));
            clock_edge();
            check({tag, ".hsel_dp"},   32'(HSEL_DP),       32'(vecs[i].dp));
            check({tag, ".hreadyout"}, 32'(DEF_HREADYOUT), 32'(vecs[i].rdy));
            check({tag, ".hresp"},     32'(DEF_HRESP),     32'(vecs[i].resp));
            check({tag, ".err_count"}, 32'(ERR_COUNT),     32'(vecs[i].cnt));
        end

        // Asynchronous reset while the default slave is in its wait cycle.
        step("err_pre_rst", 32'h2000_0000, T_NONSEQ, 1'b1, 1'b0);
        check("err_pre_rst.in_err1", 32'(DEF_HREADYOUT), 32'h0);
        drive(32'h2000_0000, T_NONSEQ, 1'b0, 1'b0);
        #1 HRESET = 1'b1;
        #1;
        model_reset();
        check("rst_mid.hsel_dp",   32'(HSEL_DP),       32'h0);
        check("rst_mid.hreadyout", 32'(DEF_HREADYOUT), 32'h1);
        check("rst_mid.hresp",     32'(DEF_HRESP),     32'h0);
        check("rst_mid.err_count", 32'(ERR_COUNT),     32'h0);
        @(negedge HCLK);
        #1 HRESET = 1'b0;

        // Drive the counter to saturation with back-to-back errors.
        for (int i = 0; i < 255; i++) begin
            step("sat_err1", 32'hA000_0000, T_NONSEQ, 1'b1, 1'b0);
            step("sat_err2", 32'hA000_0000, T_NONSEQ, 1'b0, 1'b0);
        end
        check("sat.at_255", 32'(ERR_COUNT), 32'd255);
        step("sat_extra", 32'hA000_0000, T_SEQ, 1'b1, 1'b0);
        check("sat.stays_255", 32'(ERR_COUNT), 32'd255);
        step("sat_extra2", 32'hA000_0000, T_SEQ, 1'b0, 1'b0);
        // Clear coinciding with a new error entry: clear wins.
        step("clr_vs_inc", 32'hA000_0000, T_NONSEQ, 1'b1, 1'b1);
        check("clr_vs_inc.zero", 32'(ERR_COUNT), 32'd0);
        step("clr_after", 32'h0000_0000, T_IDLE, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [1:0]  t;
            logic        rdy;
            logic        clr;
            a   = $urandom;
            t   = 2'($urandom_range(0, 3));
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            step("rand", a, t, rdy, clr);
        end
        check("rand.hrdata", DEF_HRDATA, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
